rtc_scan_sequencer: RTL

Parametrised RTC register scan sequencer: walks a configurable list of RTC address segments, issuing one access request per address to the RTC read/write controller and waiting for its completion flag. Successor of the fixed-address menu sweep FSM, with N segments, configurable inter-scan wait, selectable read/write scan mode with a latched write request, and optional FRW timeout. Sits between the menu/pointer logic and the RTC bus controller.

---
 rtl/rtc_scan_sequencer_if.sv | 25 ++
 rtl/rtc_scan_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rtc_scan_sequencer_if.sv
// Handshake bundle between the RTC scan sequencer (master) and the RTC
// read/write controller plus menu logic (slave side).
interface rtc_scan_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              frw;
  logic              scan_en;
  logic              write_req;
  logic [ADDR_W-1:0] dir;
  logic              acceso;
  logic              mod;
  logic              fbarrido;
  logic [1:0]        seg;
  logic              err;

  modport master (
    input  frw, scan_en, write_req,
    output dir, acceso, mod, fbarrido, seg, err
  );

  modport slave (
    output frw, scan_en, write_req,
    input  dir, acceso, mod, fbarrido, seg, err
  );
endinterface

// File: rtl/rtc_scan_sequencer.sv
// Walks N_SEG RTC address segments, one Acceso request per address, with optional write
// command and inter-scan wait. Define SCAN_TIMEOUT_EN to enable the FRW timeout / Err path.
module rtc_scan_sequencer #(
  parameter int unsigned                ADDR_W      = 8,
  parameter int unsigned                N_SEG       = 2,
  parameter logic [N_SEG*ADDR_W-1:0]    SEG_START   = 16'h4121,
  parameter logic [N_SEG*ADDR_W-1:0]    SEG_END     = 16'h4326,
  parameter logic [ADDR_W-1:0]          CMD_ADDR    = 8'hF0,
  parameter int unsigned                WAIT_CYC    = 3,
  parameter int unsigned                PULSE_CYC   = 7,
  parameter int unsigned                TIMEOUT_CYC = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  rtc_scan_sequencer_if.master bus
);

  localparam int unsigned PW  = $clog2(PULSE_CYC + 1);
  localparam int unsigned WCW = $clog2(WAIT_CYC + 1);
  localparam logic [1:0]  LastSeg = 2'(N_SEG - 1);

  typedef enum logic [2:0] {
    StInit, StIdle, StReq, StWack, StNext, StCmd, StWait
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] dir_q;
  logic [1:0]        seg_q;
  logic              acceso_q, mod_q, fbarrido_q, err_q;
  logic              wr_pend_q, wreq_q, cmd_issued_q;
  logic [PW-1:0]     pcnt_q;
  logic [WCW-1:0]    wcnt_q;
  logic              wreq_rise, pulse_done, timed_out;

  function automatic logic [ADDR_W-1:0] seg_start(input logic [1:0] idx);
    return SEG_START[idx*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] seg_end(input logic [1:0] idx);
    return SEG_END[idx*ADDR_W +: ADDR_W];
  endfunction

  assign wreq_rise  = bus.write_req & ~wreq_q;
  assign pulse_done = (pcnt_q == PW'(PULSE_CYC));

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  logic          awaiting_frw;

  // Counts cycles spent waiting for FRW after the request has gone out.
  assign awaiting_frw = (state_q == StWack) || ((state_q == StCmd) && cmd_issued_q);
  assign timed_out    = awaiting_frw && (tcnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if (awaiting_frw && !bus.frw) begin
      tcnt_q <= tcnt_q + TW'(1);
    end else begin
      tcnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      dir_q        <= seg_start(2'd0);
      seg_q        <= 2'd0;
      acceso_q     <= 1'b0;
      mod_q        <= 1'b0;
      fbarrido_q   <= 1'b0;
      err_q        <= 1'b0;
      wr_pend_q    <= 1'b0;
      wreq_q       <= 1'b0;
      cmd_issued_q <= 1'b0;
      pcnt_q       <= '0;
      wcnt_q       <= '0;
    end else begin
      fbarrido_q <= 1'b0;
      err_q      <= 1'b0;
      wreq_q     <= bus.write_req;
      if (wreq_rise) wr_pend_q <= 1'b1;

      unique case (state_q)
        StInit: if (bus.frw) state_q <= StIdle;
        StIdle: begin
          if (bus.scan_en) begin
            seg_q     <= 2'd0;
            dir_q     <= seg_start(2'd0);
            mod_q     <= wr_pend_q;
            // An edge arriving in the consuming cycle stays pending for the next scan.
            wr_pend_q <= wreq_rise;
            state_q   <= StReq;
          end
        end
        StReq: begin
          acceso_q <= 1'b1;
          pcnt_q   <= PW'(1);
          state_q  <= StWack;
        end
        StWack: begin
          if (bus.frw) begin
            acceso_q <= 1'b0;
            state_q  <= StNext;
          end else if (timed_out) begin
            acceso_q <= 1'b0;
            err_q    <= 1'b1;
            mod_q    <= 1'b0;
            wcnt_q   <= '0;
            state_q  <= StWait;
          end else if (acceso_q) begin
            if (pulse_done) acceso_q <= 1'b0;
            else            pcnt_q   <= pcnt_q + PW'(1);
          end
        end
        StNext: begin
          if (dir_q < seg_end(seg_q)) begin
            dir_q   <= dir_q + ADDR_W'(1);
            state_q <= StReq;
          end else if (seg_q < LastSeg) begin
            seg_q   <= seg_q + 2'd1;
            dir_q   <= seg_start(seg_q + 2'd1);
            state_q <= StReq;
          end else if (mod_q) begin
            dir_q        <= CMD_ADDR;
            cmd_issued_q <= 1'b0;
            state_q      <= StCmd;
          end else begin
            fbarrido_q <= 1'b1;
            wcnt_q     <= '0;
            state_q    <= StWait;
          end
        end
        StCmd: begin
          if (!cmd_issued_q) begin
            acceso_q     <= 1'b1;
            pcnt_q       <= PW'(1);
            cmd_issued_q <= 1'b1;
          end else if (bus.frw) begin
            acceso_q   <= 1'b0;
            fbarrido_q <= 1'b1;
            mod_q      <= 1'b0;
            wcnt_q     <= '0;
            state_q    <= StWait;
          end else if (timed_out) begin
            acceso_q <= 1'b0;
            err_q    <= 1'b1;
            mod_q    <= 1'b0;
            wcnt_q   <= '0;
            state_q  <= StWait;
          end else if (acceso_q) begin
            if (pulse_done) acceso_q <= 1'b0;
            else            pcnt_q   <= pcnt_q + PW'(1);
          end
        end
        StWait: begin
          if (wcnt_q == WCW'(WAIT_CYC - 1)) begin
            dir_q   <= seg_start(2'd0);
            seg_q   <= 2'd0;
            state_q <= StIdle;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.dir      = dir_q;
  assign bus.acceso   = acceso_q;
  assign bus.mod      = mod_q;
  assign bus.fbarrido = fbarrido_q;
  assign bus.seg      = seg_q;
  assign bus.err      = err_q;

endmodule
